// File: rtl/alu_pkg.sv
// alu_mdu shared types: op codes, FSM states and op-classification helpers.
// No logic of its own; no latency; no backpressure.
package alu_pkg;

    typedef enum logic [4:0] {
        ADD    = 5'd0,
        SUB    = 5'd1,
        SLL    = 5'd2,
        SLT    = 5'd3,
        SLTU   = 5'd4,
        XOR    = 5'd5,
        SRL    = 5'd6,
        SRA    = 5'd7,
        OR     = 5'd8,
        AND    = 5'd9,
        MUL    = 5'd10,
        MULH   = 5'd11,
        MULHSU = 5'd12,
        MULHU  = 5'd13,
        DIV    = 5'd14,
        DIVU   = 5'd15,
        REM    = 5'd16,
        REMU   = 5'd17
    } alu_op_e;

    // State names carry an S_ prefix because MUL/DIV are already op names.
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_e;

    function automatic logic is_mdu_op(input logic [4:0] op);
        return (op >= MUL) && (op <= REMU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op >= DIV) && (op <= REMU);
    endfunction

    function automatic logic is_rem_op(input logic [4:0] op);
        return (op == REM) || (op == REMU);
    endfunction

    function automatic logic is_signed_a(input logic [4:0] op);
        return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_signed_b(input logic [4:0] op);
        return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Unsigned radix-2 shift-add multiplier / restoring divider on operand magnitudes.
// XLEN cycles after load_i; last_o marks the final step; no backpressure (runs to completion).
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] opa_i,
    input  logic [XLEN-1:0] opb_i,
    output logic            last_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic             div_q;
    logic [XLEN-1:0]  acc_q;
    logic [XLEN-1:0]  lo_q;
    logic [XLEN-1:0]  opd_q;
    logic [XLEN:0]    sum;
    logic [XLEN:0]    shl;
    logic [XLEN:0]    diff;

    // Multiply: acc:lo is the partial product, lo starts as the multiplier.
    // Divide: acc is the partial remainder, lo shifts dividend out / quotient in.
    always_comb begin
        sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : {(XLEN+1){1'b0}});
        shl  = {acc_q, lo_q[XLEN-1]};
        diff = shl - {1'b0, opd_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            div_q <= 1'b0;
            acc_q <= '0;
            lo_q  <= '0;
            opd_q <= '0;
        end else if (load_i) begin
            cnt_q <= CNT_W'(XLEN);
            div_q <= is_div_i;
            acc_q <= '0;
            lo_q  <= opa_i;
            opd_q <= opb_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (div_q) begin
                if (!diff[XLEN]) begin
                    acc_q <= diff[XLEN-1:0];
                    lo_q  <= {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_q <= shl[XLEN-1:0];
                    lo_q  <= {lo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                acc_q <= sum[XLEN:1];
                lo_q  <= {sum[0], lo_q[XLEN-1:1]};
            end
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));
    assign hi_o   = acc_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/alu_mdu.sv
// RV32I ALU + M-extension unit; base/illegal ops done in cycle 1, mul/div in cycle XLEN+1.
// start is ignored while busy or in the done cycle; ALU_MDU_DIV_FASTPATH_EN finishes div-by-zero/overflow in cycle 1.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] out
);
    localparam int SHAMT_W = $clog2(XLEN);

    state_e              state_q, state_d;
    logic   [4:0]        op_q;
    logic                neg_q, bzero_q, base_q;
    logic   [XLEN-1:0]   res_q, res_d, out_q;
    logic   [XLEN-1:0]   base_res, fin_res, a_mag, b_mag, it_hi, it_lo;
    logic   [2*XLEN-1:0] prod, prod_fix;
    logic   [SHAMT_W-1:0] shamt;
    logic                a_neg, b_neg, b_zero, accept, mdu_go, load, it_last, fast_hit;

    assign shamt  = b[SHAMT_W-1:0];
    assign a_neg  = is_signed_a(op) & a[XLEN-1];
    assign b_neg  = is_signed_b(op) & b[XLEN-1];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;
    assign b_zero = (b == '0);
    assign accept = (state_q == S_IDLE) && start;

    always_comb begin
        base_res = '0;
        case (op)
            ADD:     base_res = a + b;
            SUB:     base_res = a - b;
            SLL:     base_res = a << shamt;
            SLT:     base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            SLTU:    base_res = {{(XLEN-1){1'b0}}, (a < b)};
            XOR:     base_res = a ^ b;
            SRL:     base_res = a >> shamt;
            SRA:     base_res = $signed(a) >>> shamt;
            OR:      base_res = a | b;
            AND:     base_res = a & b;
            default: base_res = '0;
        endcase
    end

`ifdef ALU_MDU_DIV_FASTPATH_EN
    logic a_min, b_m1;
    assign a_min    = (a == {1'b1, {(XLEN-1){1'b0}}});
    assign b_m1     = &b;
    assign fast_hit = is_div_op(op) & (b_zero | (is_signed_a(op) & a_min & b_m1));
    always_comb begin
        res_d = base_res;
        if (fast_hit) begin
            if (b_zero) res_d = is_rem_op(op) ? a : '1;
            else        res_d = is_rem_op(op) ? '0 : a;
        end
    end
`else
    assign fast_hit = 1'b0;
    assign res_d    = base_res;
`endif

    assign mdu_go = is_mdu_op(op) & ~fast_hit;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (mdu_go) begin
                        load    = 1'b1;
                        state_d = is_div_op(op) ? S_DIV : S_MUL;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_MUL, S_DIV: if (it_last) state_d = S_FIN;
            S_FIN:        state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    mdu_iter #(.XLEN(XLEN)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .is_div_i (is_div_op(op)),
        .opa_i    (a_mag),
        .opb_i    (b_mag),
        .last_o   (it_last),
        .hi_o     (it_hi),
        .lo_o     (it_lo)
    );

    // Divide-by-zero quotient must stay all ones, so it skips the sign flip.
    assign prod     = {it_hi, it_lo};
    assign prod_fix = neg_q ? -prod : prod;

    always_comb begin
        fin_res = res_q;
        if (!base_q) begin
            case (op_q)
                MUL:                fin_res = prod_fix[XLEN-1:0];
                MULH, MULHSU, MULHU: fin_res = prod_fix[2*XLEN-1:XLEN];
                DIV, DIVU:          fin_res = (neg_q && !bzero_q) ? -it_lo : it_lo;
                REM, REMU:          fin_res = neg_q ? -it_hi : it_hi;
                default:            fin_res = res_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            neg_q   <= 1'b0;
            bzero_q <= 1'b0;
            base_q  <= 1'b0;
            res_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= op;
                base_q  <= ~mdu_go;
                res_q   <= res_d;
                neg_q   <= is_rem_op(op) ? a_neg : (a_neg ^ b_neg);
                bzero_q <= b_zero;
            end
            if (done) out_q <= fin_res;
        end
    end

    assign done = (state_q == S_FIN);
    assign busy = (state_q != S_IDLE);
    assign out  = done ? fin_res : out_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu: vector table plus hand sequences for reset/busy corners.
module tb_alu_mdu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] out;

    logic        start16 = 1'b0;
    logic [4:0]  op16 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [15:0] out16;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef ALU_MDU_DIV_FASTPATH_EN
    localparam int DZ_LAT = 1;
`else
    localparam int DZ_LAT = 33;
`endif

    always #5 clk = ~clk;

    alu_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .out(out)
    );

    alu_mdu #(.XLEN(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .out(out16)
    );

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic addv(input string n, input logic [4:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] e, input int l);
        vec_t v;
        v.name = n; v.op = o; v.a = x; v.b = y; v.exp = e; v.lat = l;
        vt.push_back(v);
    endtask

    task automatic do_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output int lat);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = 5'($urandom_range(0, 31)); a = $urandom; b = $urandom;
        r = '0; lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done) begin
                r = out; lat = c;
                break;
            end
        end
    endtask

    task automatic do_op16(input logic [4:0] o, input logic [15:0] x, input logic [15:0] y,
                           output logic [15:0] r, output int lat);
        @(negedge clk);
        op16 = o; a16 = x; b16 = y; start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        r = '0; lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done16) begin
                r = out16; lat = c;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        logic [15:0] r16;
        int          lat;
        int          extra;

        addv("add",      ADD,    32'd7,        32'd5,        32'd12,       1);
        addv("sub",      SUB,    32'd5,        32'd7,        32'hFFFFFFFE, 1);
        addv("sll",      SLL,    32'd1,        32'h21,       32'd2,        1);
        addv("slt",      SLT,    32'hFFFFFFFF, 32'd1,        32'd1,        1);
        addv("sltu",     SLTU,   32'hFFFFFFFF, 32'd1,        32'd0,        1);
        addv("xor",      XOR,    32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1);
        addv("srl",      SRL,    32'h80000000, 32'd4,        32'h08000000, 1);
        addv("sra",      SRA,    32'h80000000, 32'h24,       32'hF8000000, 1);
        addv("or",       OR,     32'h0F,       32'hF0,       32'hFF,       1);
        addv("and",      AND,    32'hFF,       32'h0F,       32'h0F,       1);
        addv("illegal25", 5'd25, 32'h1234,     32'h5678,     32'd0,        1);
        addv("illegal31", 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1);
        addv("mul",      MUL,    32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 33);
        addv("mulh",     MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
        addv("mulhsu",   MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
        addv("mulhu",    MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        addv("div",      DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        addv("rem",      REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        addv("divu",     DIVU,   32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 33);
        addv("remu",     REMU,   32'd100,      32'd7,        32'd2,        33);
        addv("div_by0",  DIV,    32'd5,        32'd0,        32'hFFFFFFFF, DZ_LAT);
        addv("divneg_by0", DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, DZ_LAT);
        addv("remu_by0", REMU,   32'd5,        32'd0,        32'd5,        DZ_LAT);
        addv("remneg_by0", REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, DZ_LAT);
        addv("div_ovf",  DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, DZ_LAT);
        addv("rem_ovf",  REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        DZ_LAT);

        // Reset state
        #2;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_out",  out,       32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            do_op(vt[i].op, vt[i].a, vt[i].b, r, lat);
            chk({vt[i].name, "_res"}, r, vt[i].exp);
            chk({vt[i].name, "_lat"}, 32'(lat), 32'(vt[i].lat));
        end

        // Start pulsed while a MUL is busy is ignored
        @(negedge clk);
        op = MUL; a = 32'hFFFFFFFD; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_mid_mul", 32'(busy), 32'd1);
        op = ADD; a = 32'd1; b = 32'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; r = '0;
        for (int c = 5; c <= 60; c++) begin
            @(negedge clk);
            if (done) begin
                r = out; lat = c;
                break;
            end
        end
        chk("busy_ign_res", r, 32'hFFFFFFEB);
        chk("busy_ign_lat", 32'(lat), 32'd33);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("busy_ign_nodone", 32'(extra), 32'd0);
        chk("out_holds", out, 32'hFFFFFFEB);

        // Reset in the middle of a DIV aborts it
        @(negedge clk);
        op = DIV; a = 32'd100; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_out",  out,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("rst_mid_nodone", 32'(extra), 32'd0);
        do_op(ADD, 32'd7, 32'd5, r, lat);
        chk("post_rst_add_res", r, 32'd12);
        chk("post_rst_add_lat", 32'(lat), 32'd1);

        // XLEN=16 instance
        do_op16(MULHU, 16'hFFFF, 16'hFFFF, r16, lat);
        chk("x16_mulhu_res", 32'(r16), 32'h0000FFFE);
        chk("x16_mulhu_lat", 32'(lat), 32'd17);
        do_op16(5'd25, 16'h1234, 16'h4321, r16, lat);
        chk("x16_illegal_res", 32'(r16), 32'd0);
        chk("x16_illegal_lat", 32'(lat), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
